imuldiv_div_issue_unit: RTL
===========================

Name: imuldiv_div_issue_unit

Overview:
- Requester/consumer for the iterative divider's val/rdy interface.
- Accepts RISC-V DIV/DIVU/REM/REMU commands from the execute stage and drives divreq_* toward the divider.
- Collects the 64-bit divresp result {remainder[63:32], quotient[31:0]}, selects the requested half, and returns it with a tag on a val/rdy writeback port.
- Keeps one operation in flight.

Parameters:
TAG_W, 5, width of destination-register tag carried from command to writeback

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
cmd_val  input  1  command valid
cmd_rdy  output  1  command ready
cmd_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
cmd_a  input  32  dividend
cmd_b  input  32  divisor
cmd_tag  input  TAG_W  destination tag
divreq_msg_fn  output  1  1 = signed operation, 0 = unsigned
divreq_msg_a  output  32  dividend to divider
divreq_msg_b  output  32  divisor to divider
divreq_val  output  1  request valid to divider
divreq_rdy  input  1  divider ready
divresp_msg_result  input  64  {rem, quot} from divider
divresp_val  input  1  divider response valid
divresp_rdy  output  1  ready to accept divider response
wb_val  output  1  writeback valid
wb_rdy  input  1  writeback ready
wb_data  output  32  selected quotient or remainder
wb_tag  output  TAG_W  tag of completed command

Behaviour:
- Fire on any interface = val && rdy in the same cycle.
- FSM states: IDLE, REQ, WAIT, WB. Reset forces IDLE. Reset clears op, a, b, tag and result registers to 0.
- Reset values of outputs: cmd_rdy=1, divreq_val=0, divresp_rdy=0, wb_val=0; divreq_msg_*, wb_data and wb_tag are 0.
- IDLE:
  - cmd_rdy=1.
  - On cmd fire, latch op, a, b, tag and go to REQ.
- REQ:
  - divreq_val=1.
  - divreq_msg_fn = ~op[0].
  - divreq_msg_a/b driven from the latched a/b.
  - On divreq fire, go to WAIT.
  - All divreq_msg_* stay stable while divreq_val=1 and divreq_rdy=0.
- WAIT:
  - divresp_rdy=1.
  - On divresp fire, latch result[31:0] if op[1]=0, else result[63:32]. Go to WB.
- WB:
  - wb_val=1; wb_data and wb_tag come from registers.
  - On wb fire, go to IDLE.
  - wb_data/wb_tag stay stable under backpressure.
- cmd_rdy, divreq_val, divresp_rdy and wb_val are pure functions of state (Moore), with no combinational val-to-rdy paths.
- Latency:
  - cmd fire in cycle t gives divreq_val=1 in t+1.
  - divresp fire in cycle u gives wb_val=1 in u+1.
  - With the divider's 32-iteration compute and no backpressure, cmd fire to wb_val is about 36 cycles.
- Only one command is in flight. cmd_rdy=0 in REQ/WAIT/WB, so a new command is not accepted in the cycle wb fires; it is accepted in IDLE on the next cycle.
- divresp_val asserted outside WAIT is ignored: not consumed, no state change.
- Signed overflow (0x80000000 / 0xFFFFFFFF) is passed to the divider unchanged. The required results are quotient 0x80000000 and remainder 0.
- Reset asserted mid-operation returns to IDLE next cycle and discards the in-flight result. The divider shares the same reset, so no orphaned response exists.

Optional Feature:
- Macro: IMULDIV_DIV_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, a cmd fire with cmd_b==0 skips REQ/WAIT and goes directly to WB. divreq_val is never asserted.
  - WB result per RISC-V: quotient 0xFFFFFFFF for DIV and DIVU; remainder = cmd_a for REM and REMU.
  - Latency is cmd fire in t, wb_val=1 in t+1.
  - This corrects the signed divider result for negative dividend / 0.
- Not defined:
  - Zero divisors are sent to the divider like any other operation.
  - wb_data is whatever the divider returns.

Test Plan:
- DIV a=20, b=0xFFFFFFFD (-3), tag=7, all ready high -> divreq_msg_fn=1 in cycle t+1; wb_data=0xFFFFFFFA, wb_tag=7.
- REM a=0xFFFFFFF9 (-7), b=2 -> wb_data=0xFFFFFFFF. REMU with the same operands -> wb_data=0x00000001.
- DIVU a=0xFFFFFFFF, b=2 -> divreq_msg_fn=0; wb_data=0x7FFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> wb_data=0x80000000.
- Backpressure: hold divreq_rdy=0 for 5 cycles, then wb_rdy=0 for 10 cycles ->
  - divreq_msg_* stable while stalled;
  - wb_data/wb_tag stable while wb_rdy=0;
  - cmd_rdy=0 throughout;
  - exactly one wb fire.
- Reset pulse for 1 cycle while in WAIT -> next cycle: IDLE, cmd_rdy=1, wb_val=0, and no writeback for the aborted command.
- With IMULDIV_DIV_ZERO_BYPASS_EN defined, DIV a=0xFFFFFFFB (-5), b=0 -> wb_val=1 at t+1, wb_data=0xFFFFFFFF, divreq_val never 1. With the macro not defined, divreq_val is asserted and the result is taken from the divider.

Source files
------------

// File: rtl/imuldiv_div_issue_unit.sv
// Issue/collect unit between execute and the iterative divider: one operation in flight.
// Optional IMULDIV_DIV_ZERO_BYPASS_EN completes divide-by-zero locally with RISC-V results.
module imuldiv_div_issue_unit #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             cmd_val,
    output logic             cmd_rdy,
    input  logic [1:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,

    output logic             divreq_msg_fn,
    output logic [31:0]      divreq_msg_a,
    output logic [31:0]      divreq_msg_b,
    output logic             divreq_val,
    input  logic             divreq_rdy,

    input  logic [63:0]      divresp_msg_result,
    input  logic             divresp_val,
    output logic             divresp_rdy,

    output logic             wb_val,
    input  logic             wb_rdy,
    output logic [31:0]      wb_data,
    output logic [TAG_W-1:0] wb_tag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [1:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      result_q;

    logic             cmd_fire;
    logic             divreq_fire;
    logic             divresp_fire;
    logic             wb_fire;
    logic             zero_divisor;

    // Handshake outputs depend on state only, so no val-to-rdy path exists.
    assign cmd_rdy     = (state == IDLE);
    assign divreq_val  = (state == REQ);
    assign divresp_rdy = (state == WAIT);
    assign wb_val      = (state == WB);

    assign cmd_fire     = cmd_val     & cmd_rdy;
    assign divreq_fire  = divreq_val  & divreq_rdy;
    assign divresp_fire = divresp_val & divresp_rdy;
    assign wb_fire      = wb_val      & wb_rdy;

    assign zero_divisor = (cmd_b == '0);

    // fn is gated so it reads 0 outside REQ even though op_q resets to DIV.
    assign divreq_msg_fn = divreq_val & ~op_q[0];
    assign divreq_msg_a  = a_q;
    assign divreq_msg_b  = b_q;

    assign wb_data = result_q;
    assign wb_tag  = tag_q;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
`ifdef IMULDIV_DIV_ZERO_BYPASS_EN
                    state_next = zero_divisor ? WB : REQ;
`else
                    state_next = REQ;
`endif
                end
            end
            REQ: begin
                if (divreq_fire) state_next = WAIT;
            end
            WAIT: begin
                if (divresp_fire) state_next = WB;
            end
            WB: begin
                if (wb_fire) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            tag_q    <= '0;
            result_q <= '0;
        end else begin
            state <= state_next;
            if (cmd_fire) begin
                op_q  <= cmd_op;
                a_q   <= cmd_a;
                b_q   <= cmd_b;
                tag_q <= cmd_tag;
`ifdef IMULDIV_DIV_ZERO_BYPASS_EN
                if (zero_divisor) result_q <= cmd_op[1] ? cmd_a : '1;
`endif
            end
            if (divresp_fire) begin
                result_q <= op_q[1] ? divresp_msg_result[63:32] : divresp_msg_result[31:0];
            end
        end
    end

`ifndef IMULDIV_DIV_ZERO_BYPASS_EN
    logic unused_zero_divisor;
    assign unused_zero_divisor = zero_divisor;
`endif

endmodule
